// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Optional subtract mode is controlled by SERIAL_ADDER_SUB_EN (see serial_adder.sv).
package serial_adder_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      RUN  = ST_RUN,
      DONE = ST_DONE
   } state_t;

   // Bit counter must hold WIDTH-1; keep at least one bit for tiny widths.
   function automatic int count_width(input int width);
      if (width <= 2)
         return 1;
      return $clog2(width);
   endfunction

endpackage

// File: rtl/serial_adder_fa.sv
// Single-bit full-adder cell used by serial_adder for each processed bit.
module fa (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one fa evaluation per clock, LSB first.
// Define SERIAL_ADDER_SUB_EN to add a `sub` input selecting a - b.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             c_out
);

   localparam int CW = count_width(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] op_a_reg, op_a_next;
   logic [WIDTH-1:0] op_b_reg, op_b_next;
   logic [WIDTH-1:0] res_reg, res_next;
   logic [WIDTH-1:0] sum_reg, sum_next;
   logic [CW-1:0]    count_reg, count_next;
   logic             carry_reg, carry_next;
   logic             c_out_reg, c_out_next;

   logic [WIDTH-1:0] b_load;
   logic             c_load;
   logic             fa_s;
   logic             fa_co;

`ifdef SERIAL_ADDER_SUB_EN
   // Two's-complement subtract: a + ~b + 1; c_out=1 then means no borrow.
   assign b_load = sub ? ~b : b;
   assign c_load = sub ? 1'b1 : c_in;
`else
   assign b_load = b;
   assign c_load = c_in;
`endif

   fa u_fa (
      .a  (op_a_reg[0]),
      .b  (op_b_reg[0]),
      .ci (carry_reg),
      .s  (fa_s),
      .co (fa_co)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         op_a_reg  <= '0;
         op_b_reg  <= '0;
         res_reg   <= '0;
         sum_reg   <= '0;
         count_reg <= '0;
         carry_reg <= 1'b0;
         c_out_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         op_a_reg  <= op_a_next;
         op_b_reg  <= op_b_next;
         res_reg   <= res_next;
         sum_reg   <= sum_next;
         count_reg <= count_next;
         carry_reg <= carry_next;
         c_out_reg <= c_out_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      op_a_next  = op_a_reg;
      op_b_next  = op_b_reg;
      res_next   = res_reg;
      sum_next   = sum_reg;
      count_next = count_reg;
      carry_next = carry_reg;
      c_out_next = c_out_reg;

      case (state_reg)
         IDLE, DONE: begin
            if (start) begin
               op_a_next  = a;
               op_b_next  = b_load;
               carry_next = c_load;
               count_next = '0;
               state_next = RUN;
            end else begin
               state_next = IDLE;
            end
         end
         RUN: begin
            // Sum bits enter at the MSB so after WIDTH shifts bit 0 is the LSB.
            op_a_next  = {1'b0, op_a_reg[WIDTH-1:1]};
            op_b_next  = {1'b0, op_b_reg[WIDTH-1:1]};
            res_next   = {fa_s, res_reg[WIDTH-1:1]};
            carry_next = fa_co;
            count_next = count_reg + CW'(1);
            if (count_reg == LAST_BIT) begin
               sum_next   = {fa_s, res_reg[WIDTH-1:1]};
               c_out_next = fa_co;
               state_next = DONE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign busy  = (state_reg == RUN);
   assign done  = (state_reg == DONE);
   assign sum   = sum_reg;
   assign c_out = c_out_reg;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed table, corner sequences, random ops.
module tb_serial_adder;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         c_in;
   logic         sub_in;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         c_out;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         ci;
      logic         sub;
      logic [W-1:0] exp_sum;
      logic         exp_co;
      string        name;
   } vec_t;

   vec_t vecs[$];

   serial_adder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .c_in  (c_in),
`ifdef SERIAL_ADDER_SUB_EN
      .sub   (sub_in),
`endif
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .c_out (c_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operand values.
   function automatic logic [W:0] ref_model(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                            input logic rci, input logic rsub);
      int unsigned ia, ib;
      ia = ra;
      ib = rb;
      if (rsub)
         return {(ia >= ib) ? 1'b1 : 1'b0, W'((ia - ib) % (1 << W))};
      return (W+1)'(ia + ib + rci);
   endfunction

   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tci,
                         input logic tsub, input logic [W-1:0] esum, input logic eco,
                         input string nm);
      logic [W-1:0] held;
      bit ok;
      @(negedge clk);
      held   = sum;
      a      = ta;
      b      = tb_v;
      c_in   = tci;
      sub_in = tsub;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start  = 1'b0;
      a      = W'($urandom);
      b      = W'($urandom);
      c_in   = 1'($urandom);
      sub_in = 1'($urandom);
      ok = 1;
      for (int i = 0; i < W; i++) begin
         @(negedge clk);
         if (!(busy === 1'b1 && done === 1'b0 && sum === held)) ok = 0;
      end
      check({nm, " busy window"}, 32'(ok), 32'd1);
      @(negedge clk);
      check({nm, " done"}, 32'(done), 32'd1);
      check({nm, " busy low"}, 32'(busy), 32'd0);
      check({nm, " sum"}, 32'(sum), 32'(esum));
      check({nm, " c_out"}, 32'(c_out), 32'(eco));
      $display("op %s: a=0x%0h b=0x%0h ci=%0d sub=%0d -> sum=0x%0h c_out=%0d", nm, ta, tb_v,
               tci, tsub, sum, c_out);
      @(negedge clk);
      check({nm, " done pulse"}, 32'(done), 32'd0);
   endtask

   initial begin
      logic [W:0]   r;
      logic [W-1:0] ra, rb;
      logic         rci, rsub;
      bit           ok;
      int           done_cnt, t1, t2;
      logic [W-1:0] s1, s2;

      rst_n  = 1'b0;
      start  = 1'b0;
      a      = '0;
      b      = '0;
      c_in   = 1'b0;
      sub_in = 1'b0;
      #1;
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset sum", 32'(sum), 32'd0);
      check("reset c_out", 32'(c_out), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      vecs.push_back('{8'h05, 8'h03, 1'b0, 1'b0, 8'h08, 1'b0, "basic"});
      vecs.push_back('{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, "wrap"});
      vecs.push_back('{8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, "cin"});
      vecs.push_back('{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, "max"});
      vecs.push_back('{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, "zero"});
`ifdef SERIAL_ADDER_SUB_EN
      vecs.push_back('{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, "sub_borrow"});
      vecs.push_back('{8'h09, 8'h04, 1'b1, 1'b1, 8'h05, 1'b1, "sub_noborrow"});
      vecs.push_back('{8'h33, 8'h33, 1'b0, 1'b1, 8'h00, 1'b1, "sub_equal"});
`endif
      foreach (vecs[i])
         run_op(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sub, vecs[i].exp_sum,
                vecs[i].exp_co, vecs[i].name);

      // Busy guard: a start pulse mid-RUN must be ignored.
      @(negedge clk);
      a = 8'h12; b = 8'h34; c_in = 1'b0; sub_in = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int i = 0; i < W; i++) begin
         @(negedge clk);
         if (i == 2) begin
            a = 8'hAA; b = 8'h55; c_in = 1'b1; start = 1'b1;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      @(negedge clk);
      check("guard done", 32'(done), 32'd1);
      check("guard sum", 32'(sum), 32'h46);
      check("guard c_out", 32'(c_out), 32'd0);
      $display("op guard: sum=0x%0h c_out=%0d", sum, c_out);
      ok = 1;
      for (int i = 0; i < 2 * W; i++) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) ok = 0;
      end
      check("guard single done", 32'(ok), 32'd1);

      // Back-to-back with start held high.
      @(negedge clk);
      a = 8'h10; b = 8'h20; c_in = 1'b0; sub_in = 1'b0; start = 1'b1;
      @(posedge clk);
      #1;
      a = 8'h01; b = 8'h02;
      done_cnt = 0; t1 = 0; t2 = 0; s1 = '0; s2 = '0;
      for (int i = 1; i <= 3 * W && done_cnt < 2; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            done_cnt++;
            if (done_cnt == 1) begin t1 = i; s1 = sum; end
            else begin t2 = i; s2 = sum; start = 1'b0; end
         end
      end
      start = 1'b0;
      check("b2b done count", 32'(done_cnt), 32'd2);
      check("b2b spacing", 32'(t2 - t1), 32'(W + 1));
      check("b2b sum1", 32'(s1), 32'h30);
      check("b2b sum2", 32'(s2), 32'h03);
      $display("op b2b: sum1=0x%0h sum2=0x%0h spacing=%0d", s1, s2, t2 - t1);
      repeat (W + 3) @(negedge clk);
      check("b2b idle", 32'(busy), 32'd0);

      // Reset in the middle of RUN.
      @(negedge clk);
      a = 8'h0F; b = 8'h0F; c_in = 1'b1; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst busy", 32'(busy), 32'd0);
      check("midrst sum", 32'(sum), 32'd0);
      check("midrst c_out", 32'(c_out), 32'd0);
      check("midrst done", 32'(done), 32'd0);
      $display("op midreset: busy=%0d sum=0x%0h c_out=%0d", busy, sum, c_out);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      ok = 1;
      for (int i = 0; i < W + 2; i++) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) ok = 0;
      end
      check("midrst no done", 32'(ok), 32'd1);
      run_op(8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, "after_reset");

      // Random operations against the arithmetic model.
      for (int i = 0; i < 40; i++) begin
         ra  = W'($urandom);
         rb  = W'($urandom);
         rci = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
         rsub = 1'($urandom);
`else
         rsub = 1'b0;
`endif
         r = ref_model(ra, rb, rci, rsub);
         run_op(ra, rb, rci, rsub, r[W-1:0], r[W], $sformatf("rand%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
